// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA-1 message padder.
// PadState enumerates the padder FSM; constants describe block layout.
package sha_pkg;

  localparam int BLOCK_W = 512;
  localparam int LEN_BYTE_POS = 56;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    FILL,
    PAD80,
    ZERO,
    LEN,
    ISSUE,
    WAIT0,
    WAIT
  } PadState;

endpackage

// File: rtl/sha1_msg_padder.sv
// Packs an AXI-Stream byte stream into padded 512-bit SHA-1 blocks.
// Ports: s_axis_* byte input, core_* init/next/block to sha1_core, msg_done, busy.
module sha1_msg_padder
  import sha_pkg::*;
#(
  parameter int CNT_W = 29
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tlast,
  input  logic               core_ready,
  output logic               core_init,
  output logic               core_next,
  output logic [BLOCK_W-1:0] core_block,
  output logic               msg_done,
  output logic               busy
);

  PadState            state_q;
  PadState            ret_q;
  logic [5:0]         idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               first_q;
  logic               final_q;
  logic [BLOCK_W-1:0] block_q;
  logic               init_q;
  logic               next_q;
  logic               done_q;

  logic [8:0]         hi;
  logic [63:0]        bit_len;

  // byte i lives at [511-8*i -: 8]
  assign hi = 9'(BLOCK_W - 1) - {idx_q, 3'b000};
  assign bit_len = 64'({cnt_q, 3'b000});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      ret_q   <= FILL;
      idx_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
      final_q <= 1'b0;
      block_q <= '0;
      init_q  <= 1'b0;
      next_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      init_q <= 1'b0;
      next_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        FILL: begin
          if (s_axis_tvalid) begin
            block_q[hi -: 8] <= s_axis_tdata;
            idx_q <= idx_q + 6'd1;
            cnt_q <= cnt_q + 1'b1;
            if (idx_q == 6'd63) begin
              // full block goes out before any padding
              final_q <= 1'b0;
              ret_q   <= s_axis_tlast ? PAD80 : FILL;
              state_q <= ISSUE;
            end else if (s_axis_tlast) begin
              state_q <= PAD80;
            end
          end
        end
        PAD80: begin
          block_q[hi -: 8] <= PAD_BYTE;
          idx_q <= idx_q + 6'd1;
          if (idx_q == 6'd63) begin
            final_q <= 1'b0;
            ret_q   <= ZERO;
            state_q <= ISSUE;
          end else begin
            // ZERO also covers the no-room-for-length case
            state_q <= ZERO;
          end
        end
        ZERO: begin
          if (idx_q == 6'(LEN_BYTE_POS)) begin
            state_q <= LEN;
          end else begin
            block_q[hi -: 8] <= 8'h00;
            idx_q <= idx_q + 6'd1;
            if (idx_q == 6'd63) begin
              final_q <= 1'b0;
              ret_q   <= ZERO;
              state_q <= ISSUE;
            end
          end
        end
        LEN: begin
          block_q[63:0] <= bit_len;
          idx_q   <= '0;
          final_q <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: begin
          if (core_ready) begin
            init_q  <= first_q;
            next_q  <= ~first_q;
            done_q  <= final_q;
            first_q <= 1'b0;
            state_q <= WAIT0;
          end
        end
        // core deasserts ready one cycle late
        WAIT0: state_q <= WAIT;
        WAIT: begin
          if (core_ready) begin
            block_q <= '0;
            if (final_q) begin
              cnt_q   <= '0;
              first_q <= 1'b1;
              state_q <= FILL;
            end else begin
              state_q <= ret_q;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign s_axis_tready = rst_n & (state_q == FILL);
  assign core_init = init_q;
  assign core_next = next_q;
  assign msg_done = done_q;
  assign core_block = block_q;
  assign busy = ~((state_q == FILL) && (idx_q == 6'd0)
                  && (cnt_q == '0));

endmodule
